// File: rtl/led_anim_pkg.sv
// Shared types and constants for the LED animation sequencer.
package led_anim_pkg;

  localparam int STEP_W  = 7;
  localparam int FRAME_W = 4;

  localparam logic [STEP_W-1:0] LED_OFF   = 7'h7F;
  localparam logic [STEP_W-1:0] STEP_LAST = 7'd127;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HOLD = 2'd2,
    ST_DONE = 2'd3
  } anim_state_e;

endpackage

// File: rtl/anim_prescaler.sv
// Step-rate prescaler: counts enabled clocks and pulses tick every CLK_DIV of them.
module anim_prescaler #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int CW = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(CLK_DIV - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  assign tick = en && (cnt_q == CNT_LAST);

  // Count is held (not cleared) while en is low so a pause resumes mid-interval.
  always_comb begin
    cnt_d = cnt_q;
    if (clr || tick) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/led_anim_sequencer.sv
// Steps a 7-bit index through NUM_FRAMES decoder frames and registers the
// selected active-low pattern onto the LED pins.
//
//   state   | meaning
//   IDLE    | stopped, LEDs blank, step/frame at 0
//   RUN     | prescaler running, step advances on every tick
//   HOLD    | paused, step/frame/prescaler frozen, LEDs still driven
//   DONE    | last frame finished without loop, LEDs blank, position held
module led_anim_sequencer
  import led_anim_pkg::*;
#(
  parameter int CLK_DIV    = 4,
  parameter int NUM_FRAMES = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               stop,
  input  logic               pause,
  input  logic               dir,
  input  logic               loop_en,
  input  logic [STEP_W-1:0]  pat_in,
  output logic [STEP_W-1:0]  step,
  output logic [FRAME_W-1:0] frame,
  output logic [STEP_W-1:0]  led_n,
  output logic               busy,
  output logic               done
);

  localparam logic [FRAME_W-1:0] FRAME_LAST = FRAME_W'(NUM_FRAMES - 1);

  anim_state_e        state_q, state_d;
  logic [STEP_W-1:0]  step_q, step_d;
  logic [FRAME_W-1:0] frame_q, frame_d;
  logic [STEP_W-1:0]  led_q, led_d;
  logic               dir_q, dir_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  logic               active;
  logic               tick;
  logic [STEP_W-1:0]  step_adv;
  logic               step_wrap;
  logic               frame_wrap;

  assign active = (state_q == ST_RUN) || (state_q == ST_HOLD);

  anim_prescaler #(.CLK_DIV(CLK_DIV)) u_prescaler (
    .clk  (clk),
    .rst_n(rst_n),
    .en   (active && !pause && !stop && !start),
    .clr  (stop || start),
    .tick (tick)
  );

  assign step_adv   = dir_q ? (step_q - 7'd1) : (step_q + 7'd1);
  assign step_wrap  = dir_q ? (step_q == '0) : (step_q == STEP_LAST);
  assign frame_wrap = (frame_q == FRAME_LAST);

  always_comb begin
    state_d = state_q;
    step_d  = step_q;
    frame_d = frame_q;
    dir_d   = dir_q;
    done_d  = 1'b0;
    if (stop) begin
      state_d = ST_IDLE;
      step_d  = '0;
      frame_d = '0;
    end else if (start) begin
      state_d = ST_RUN;
      dir_d   = dir;
      step_d  = dir ? STEP_LAST : '0;
      frame_d = '0;
    end else if (active) begin
      state_d = pause ? ST_HOLD : ST_RUN;
      if (tick) begin
        if (step_wrap && frame_wrap && !loop_en) begin
          state_d = ST_DONE;
          done_d  = 1'b1;
        end else begin
          step_d = step_adv;
          if (step_wrap) begin
            frame_d = frame_wrap ? '0 : frame_q + FRAME_W'(1);
          end
        end
      end
    end
    busy_d = (state_d == ST_RUN) || (state_d == ST_HOLD);
    led_d  = busy_d ? pat_in : LED_OFF;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      step_q  <= '0;
      frame_q <= '0;
      led_q   <= LED_OFF;
      dir_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
      frame_q <= frame_d;
      led_q   <= led_d;
      dir_q   <= dir_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign step  = step_q;
  assign frame = frame_q;
  assign led_n = led_q;
  assign busy  = busy_q;
  assign done  = done_q;

endmodule

// File: tb/tb_led_anim_sequencer.sv
// Bench for led_anim_sequencer: directed scenarios plus random control traffic
// checked against a position/phase reference model.
module tb_led_anim_sequencer;

  localparam int CLK_DIV = 4;
  localparam int NF      = 2;
  localparam int SPAN    = 128;
  localparam int RUN_LEN = NF * SPAN * CLK_DIV;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       start = 1'b0, stop = 1'b0, pause = 1'b0, dir = 1'b0, loop_en = 1'b0;
  logic [6:0] pat_in, step, led_n;
  logic [3:0] frame;
  logic       busy, done;

  int checks = 0;
  int errors = 0;

  // model: mode 0 idle, 1 run, 2 hold, 3 done; pos = ticks since start
  int         m_mode, m_pos, m_phase;
  bit         m_dir, m_done;
  logic [6:0] m_led;

  led_anim_sequencer #(.CLK_DIV(CLK_DIV), .NUM_FRAMES(NF)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .pause(pause),
    .dir(dir), .loop_en(loop_en), .pat_in(pat_in), .step(step),
    .frame(frame), .led_n(led_n), .busy(busy), .done(done)
  );

  assign pat_in = ~step;

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [6:0] exp_step();
    int s;
    if (m_mode == 0) return 7'd0;
    s = m_dir ? (SPAN - 1 - (m_pos % SPAN)) : (m_pos % SPAN);
    return 7'(s);
  endfunction

  function automatic logic [3:0] exp_frame();
    if (m_mode == 0) return 4'd0;
    return 4'(m_pos / SPAN);
  endfunction

  task automatic model_reset();
    m_mode = 0; m_pos = 0; m_phase = 0; m_dir = 0; m_done = 0; m_led = 7'h7F;
  endtask

  task automatic check_all();
    chk("step",  32'(step),  32'(exp_step()));
    chk("frame", 32'(frame), 32'(exp_frame()));
    chk("led_n", 32'(led_n), 32'(m_led));
    chk("busy",  32'(busy),  32'((m_mode == 1) || (m_mode == 2)));
    chk("done",  32'(done),  32'(m_done));
  endtask

  task automatic cycle();
    logic [6:0] old_step;
    old_step = exp_step();
    m_done = 0;
    if (stop) begin
      m_mode = 0; m_pos = 0; m_phase = 0;
    end else if (start) begin
      m_mode = 1; m_dir = dir; m_pos = 0; m_phase = 0;
    end else if (m_mode == 1 || m_mode == 2) begin
      m_mode = pause ? 2 : 1;
      if (!pause) begin
        m_phase++;
        if (m_phase == CLK_DIV) begin
          m_phase = 0;
          m_pos++;
          if (m_pos == NF * SPAN) begin
            if (loop_en) m_pos = 0;
            else begin
              m_pos = NF * SPAN - 1; m_mode = 3; m_done = 1;
            end
          end
        end
      end
    end
    m_led = (m_mode == 1 || m_mode == 2) ? ~old_step : 7'h7F;
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic pulse_start(input logic d);
    dir = d; start = 1'b1;
    cycle();
    start = 1'b0;
  endtask

  task automatic async_reset();
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    chk("rst_step",  32'(step),  32'd0);
    chk("rst_frame", 32'(frame), 32'd0);
    chk("rst_led",   32'(led_n), 32'h7F);
    chk("rst_busy",  32'(busy),  32'd0);
    chk("rst_done",  32'(done),  32'd0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    start = 1'b0; stop = 1'b0; pause = 1'b0;
  endtask

  initial begin
    logic [6:0] held;
    int guard;
    model_reset();
    #2;
    rst_n = 1'b0;
    #1;
    check_all();
    chk("rst_led0", 32'(led_n), 32'h7F);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // 1: start up-count, first step after CLK_DIV clocks
    loop_en = 1'b0;
    pulse_start(1'b0);
    chk("t1_busy", 32'(busy), 32'd1);
    cycles(CLK_DIV);
    chk("t1_step1", 32'(step), 32'd1);
    cycle();
    chk("t1_led", 32'(led_n), 32'h7E);

    // 2: run to the end without loop, done pulse for one clock
    guard = 0;
    while (!m_done && guard < RUN_LEN + 16) begin
      cycle();
      guard++;
    end
    chk("t2_reached_done", 32'(m_done), 32'd1);
    chk("t2_done", 32'(done), 32'd1);
    chk("t2_led",  32'(led_n), 32'h7F);
    chk("t2_busy", 32'(busy), 32'd0);
    cycle();
    chk("t2_done_once", 32'(done), 32'd0);
    cycles(5);

    // 3: looping wraps back to frame 0 with no done pulse
    loop_en = 1'b1;
    pulse_start(1'b0);
    cycles(RUN_LEN + 20);
    chk("t3_busy", 32'(busy), 32'd1);

    // 4: pause mid-interval freezes everything, then resumes where it left off
    pulse_start(1'b0);
    cycles(2);
    held = step;
    pause = 1'b1;
    cycles(10);
    chk("t4_frozen", 32'(step), 32'(held));
    pause = 1'b0;
    cycles(2);
    chk("t4_resume", 32'(step), 32'(held + 7'd1));
    cycles(20);

    // 5: start and stop together, stop wins
    cycles(50);
    start = 1'b1; stop = 1'b1;
    cycle();
    start = 1'b0; stop = 1'b0;
    chk("t5_step", 32'(step), 32'd0);
    chk("t5_led",  32'(led_n), 32'h7F);
    chk("t5_busy", 32'(busy), 32'd0);
    cycles(5);

    // 6: down-count then asynchronous reset mid-frame
    pulse_start(1'b1);
    chk("t6_step127", 32'(step), 32'd127);
    cycles(CLK_DIV);
    chk("t6_step126", 32'(step), 32'd126);
    cycles(300);
    async_reset();
    cycles(3);

    // random control traffic
    for (int i = 0; i < 30000; i++) begin
      start   = ($urandom_range(0, 1499) == 0);
      stop    = ($urandom_range(0, 2999) == 0);
      dir     = $urandom_range(0, 1);
      loop_en = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 15) == 0) pause = ~pause;
      cycle();
      if ($urandom_range(0, 9999) == 0) async_reset();
    end
    start = 1'b0; stop = 1'b0; pause = 1'b0;
    cycles(4);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
